// File: rtl/dec_rr_arbiter16.sv
// dec_rr_arbiter16: 16-way round-robin arbiter with a decoded one-hot grant, a binary index,
// and hold-limit force release.
module dec_rr_arbiter16 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] req_i,
  input  logic        done_i,
  output logic [15:0] gnt_o,
  output logic [3:0]  gnt_idx_o,
  output logic        gnt_vld_o,
  output logic        timeout_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d, ptr_q, ptr_d, off;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic [15:0]      gnt_q, gnt_d, rot;
  logic [31:0]      dbl;
  logic             any, release_now, hold_hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      gnt_q   <= gnt_d;
    end
  end
  // Rotate requests so that bit 0 is the pointer position; the first set bit is the winner's offset.
  always_comb begin
    dbl = {req_i, req_i} >> ptr_q;
    rot = dbl[15:0];
    off = '0;
    for (int i = 15; i >= 0; i--)
      if (rot[i]) off = 4'(i);
  end
  assign any         = |req_i;
  assign release_now = done_i || !req_i[idx_q];
  assign hold_hit    = (MAX_HOLD != 0) && (cnt_q == LIM);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (en_i && any) begin
        state_d = BUSY;
        idx_d   = ptr_q + off;
        ptr_d   = ptr_q + off + 4'd1;
        cnt_d   = '0;
      end
    end else begin
      state_d = (release_now || hold_hit) ? IDLE : BUSY;
      to_d    = !release_now && hold_hit;
      cnt_d   = (release_now || hold_hit) ? cnt_q : cnt_q + 1'b1;
    end
  end
  // Decoder: select is the next index, enable is the next valid.
  always_comb begin
    gnt_d = '0;
    if (state_d == BUSY) gnt_d[idx_d] = 1'b1;
  end
  always_comb begin
    gnt_o     = gnt_q;
    gnt_idx_o = idx_q;
    gnt_vld_o = state_q == BUSY;
    timeout_o = to_q;
  end
endmodule

// File: tb/tb_dec_rr_arbiter16.sv
// tb_dec_rr_arbiter16: directed checks of reset, round robin, hold timeout, enable and request drop.
module tb_dec_rr_arbiter16;
  logic        clk = 1'b0;
  logic        rst, en, done;
  logic [15:0] req, gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld, timeout;
  int          tests = 0, fails = 0;
  int          order [5] = '{0, 4, 15, 0, 4};
  dec_rr_arbiter16 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en_i(en), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_idx_o(gnt_idx), .gnt_vld_o(gnt_vld), .timeout_o(timeout)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [15:0] g, input logic [3:0] i, input logic v, input logic t);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(i));
    chk({tag, ".vld"}, 32'(gnt_vld), 32'(v));
    chk({tag, ".to"}, 32'(timeout), 32'(t));
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; done = 1'b0; req = '0;
    step();
    chk_all("rst1", 16'h0, 4'd0, 1'b0, 1'b0);
    step();
    chk_all("rst2", 16'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    done = 1'b1;
    step();
    chk_all("idle_done", 16'h0, 4'd0, 1'b0, 1'b0);
    done = 1'b0;
    req = 16'h0020;
    step();
    chk_all("single_c1", 16'h0020, 4'd5, 1'b1, 1'b0);
    step();
    chk_all("single_c2", 16'h0020, 4'd5, 1'b1, 1'b0);
    step();
    chk_all("single_c3", 16'h0020, 4'd5, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_all("single_c4", 16'h0000, 4'd5, 1'b0, 1'b0);
    done = 1'b0;
    step();
    chk_all("single_c5", 16'h0020, 4'd5, 1'b1, 1'b0);
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0; req = 16'h8011;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr%0d.idx", k), 32'(gnt_idx), 32'(order[k]));
      chk($sformatf("rr%0d.gnt", k), 32'(gnt), 32'h1 << order[k]);
      done = 1'b1;
      step();
      chk($sformatf("rr%0d.gap", k), 32'(gnt), 32'h0);
      done = 1'b0;
    end
    req = 16'h0002;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk_all($sformatf("to_c%0d", c), 16'h0002, 4'd1, 1'b1, 1'b0);
    end
    step();
    chk_all("to_c9", 16'h0000, 4'd1, 1'b0, 1'b1);
    step();
    chk_all("to_c10", 16'h0002, 4'd1, 1'b1, 1'b0);
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0; en = 1'b0; req = 16'hFFFF;
    step();
    step();
    chk_all("en_off", 16'h0000, 4'd0, 1'b0, 1'b0);
    en = 1'b1;
    step();
    chk_all("en_on", 16'h0001, 4'd0, 1'b1, 1'b0);
    req = 16'hFFFE;
    step();
    chk_all("req_drop", 16'h0000, 4'd0, 1'b0, 1'b0);
    step();
    chk_all("next_g1", 16'h0002, 4'd1, 1'b1, 1'b0);
    en = 1'b0;
    for (int c = 0; c < 7; c++) step();
    chk_all("en_hold", 16'h0002, 4'd1, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_all("done_vs_to", 16'h0000, 4'd1, 1'b0, 1'b0);
    done = 1'b0; en = 1'b1;
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0; req = 16'h0400;
    step();
    chk_all("pre_rst", 16'h0400, 4'd10, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_all("mid_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst = 1'b0; req = 16'h0401;
    step();
    chk_all("post_rst", 16'h0001, 4'd0, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
